// File: rtl/top_racl_pkg.sv
// rtl/top_racl_pkg.sv - RACL error record types plus collector helpers
//
// Purpose : shared types for the RACL error log collector. Holds the
//           racl_error_log_t record produced by the per-IP RACL checks,
//           the maximum source count, the source index type, the collector
//           state type and the overflow merge helper.
// Ports   : none (package).
// Config  : the RACL_ERR_CNT_EN macro is consumed by the interface and top,
//           not by this package.
package top_racl_pkg;

   localparam int unsigned NrRaclBits     = 4;
   localparam int unsigned NrCtnUidBits   = 8;
   localparam int unsigned RaclAddrW      = 32;
   localparam int unsigned RACL_ERR_SRC_MAX = 16;

   typedef logic [NrRaclBits-1:0]   racl_role_t;
   typedef logic [NrCtnUidBits-1:0] ctn_uid_t;

   typedef struct packed {
      logic                 valid;
      logic                 overflow;
      racl_role_t           racl_role;
      ctn_uid_t             ctn_uid;
      logic                 read_access;
      logic [RaclAddrW-1:0] request_address;
   } racl_error_log_t;

   // Wide enough for any legal source count.
   typedef logic [$clog2(RACL_ERR_SRC_MAX)-1:0] racl_src_idx_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HELD  = 1'b1
   } racl_log_state_e;

   // Width of a source index for a given number of sources.
   function automatic int unsigned racl_src_w(input int unsigned num_src);
      return (num_src <= 1) ? 1 : $clog2(num_src);
   endfunction

   // A captured record overflows if the winner already lost records
   // upstream or if it shared its capture cycle with another source.
   function automatic logic racl_merge_overflow(input logic rec_overflow,
                                                input logic multi_valid);
      return rec_overflow | multi_valid;
   endfunction

endpackage

// File: rtl/racl_error_log_collector_if.sv
// rtl/racl_error_log_collector_if.sv - signal bundle between RACL sources, collector and CSRs
//
// Purpose : groups the per-source records, the CSR clear pulse and the
//           captured log outputs of racl_error_log_collector.
// Signals : err_log_i  NumSrc x racl_error_log_t  per-source denial records
//           clear_i    1                          CSR clear pulse
//           err_log_o  racl_error_log_t           captured record
//           err_src_o  SrcW                       index of captured source
//           intr_o     1                          level interrupt
//           err_cnt_o  NumSrc x CntW              per-source counts (RACL_ERR_CNT_EN only)
// Modports: master drives records/clear, slave is the collector.
// Config  : RACL_ERR_CNT_EN adds err_cnt_o.
interface racl_error_log_collector_if
   import top_racl_pkg::*;
#(
   parameter int unsigned NumSrc = 4,
   parameter int unsigned CntW   = 8
);
   localparam int unsigned SrcW = racl_src_w(NumSrc);

   racl_error_log_t [NumSrc-1:0] err_log_i;
   logic                         clear_i;
   racl_error_log_t              err_log_o;
   logic [SrcW-1:0]              err_src_o;
   logic                         intr_o;
`ifdef RACL_ERR_CNT_EN
   logic [NumSrc-1:0][CntW-1:0]  err_cnt_o;

   modport master (
      output err_log_i, clear_i,
      input  err_log_o, err_src_o, intr_o, err_cnt_o
   );
   modport slave (
      input  err_log_i, clear_i,
      output err_log_o, err_src_o, intr_o, err_cnt_o
   );
`else
   modport master (
      output err_log_i, clear_i,
      input  err_log_o, err_src_o, intr_o
   );
   modport slave (
      input  err_log_i, clear_i,
      output err_log_o, err_src_o, intr_o
   );
`endif

endinterface

// File: rtl/racl_err_rr_arb.sv
// rtl/racl_err_rr_arb.sv - round-robin pick among RACL error sources
//
// Purpose : combinational round-robin selection with a registered pointer.
//           The search starts at the pointer and wraps; on advance_i the
//           pointer moves to winner+1 (mod NumSrc).
// Ports   : clk_i        clock
//           rst_ni       synchronous active-low reset (pointer -> 0)
//           req_i        NumSrc request bits
//           advance_i    a capture used the current grant
//           gnt_idx_o    index of the granted source
//           any_valid_o  at least one request is set
module racl_err_rr_arb
   import top_racl_pkg::*;
#(
   parameter int unsigned NumSrc = 4,
   parameter int unsigned SrcW   = racl_src_w(NumSrc)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NumSrc-1:0] req_i,
   input  logic              advance_i,
   output logic [SrcW-1:0]   gnt_idx_o,
   output logic              any_valid_o
);

   logic [SrcW-1:0] r_ptr;
   logic [SrcW-1:0] w_gnt;
   logic            w_found;
   logic [SrcW:0]   w_sum;
   logic [SrcW-1:0] w_idx;

   // One extra bit on the sum keeps ptr+offset from wrapping early when
   // NumSrc is not a power of two.
   always_comb begin
      w_gnt   = '0;
      w_found = 1'b0;
      w_sum   = '0;
      w_idx   = '0;
      for (int i = 0; i < int'(NumSrc); i++) begin
         w_sum = {1'b0, r_ptr} + (SrcW+1)'(i);
         if (w_sum >= (SrcW+1)'(NumSrc)) begin
            w_sum = w_sum - (SrcW+1)'(NumSrc);
         end
         w_idx = w_sum[SrcW-1:0];
         if (!w_found && req_i[w_idx]) begin
            w_found = 1'b1;
            w_gnt   = w_idx;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_ptr <= '0;
      end else if (advance_i && w_found) begin
         r_ptr <= (w_gnt == SrcW'(NumSrc - 1)) ? '0 : w_gnt + SrcW'(1);
      end
   end

   assign gnt_idx_o   = w_gnt;
   assign any_valid_o = w_found;

endmodule

// File: rtl/racl_error_log_collector.sv
// rtl/racl_error_log_collector.sv - single-entry RACL error log with sticky overflow
//
// Purpose : collects RACL denial records from NumSrc endpoints, captures one
//           via round-robin, holds it until a CSR clear, merges lost records
//           into a sticky overflow flag and raises a level interrupt.
// Ports   : clk_i   clock
//           rst_ni  synchronous active-low reset
//           bus     racl_error_log_collector_if.slave (records in, clear in,
//                   captured log / source / interrupt / counts out)
// Config  : RACL_ERR_CNT_EN enables saturating per-source denial counters
//           driven onto bus.err_cnt_o.
module racl_error_log_collector
   import top_racl_pkg::*;
#(
   parameter int unsigned NumSrc = 4,
   parameter int unsigned CntW   = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   racl_error_log_collector_if.slave bus
);

   localparam int unsigned SrcW = racl_src_w(NumSrc);

   racl_log_state_e r_state;
   racl_error_log_t r_log;
   logic [SrcW-1:0] r_src;

   logic [NumSrc-1:0] w_req;
   logic [SrcW-1:0]   w_gnt;
   logic              w_any;
   logic              w_multi;
   logic              w_seen;
   logic              w_cap;

   always_comb begin
      w_req   = '0;
      w_multi = 1'b0;
      w_seen  = 1'b0;
      for (int k = 0; k < int'(NumSrc); k++) begin
         w_req[k] = bus.err_log_i[k].valid;
         if (bus.err_log_i[k].valid) begin
            if (w_seen) w_multi = 1'b1;
            w_seen = 1'b1;
         end
      end
   end

   // A capture happens from EMPTY, or from HELD when the clear releases the
   // slot in the same cycle a new record arrives.
   assign w_cap = w_any && ((r_state == ST_EMPTY) || bus.clear_i);

   racl_err_rr_arb #(
      .NumSrc (NumSrc),
      .SrcW   (SrcW)
   ) u_arb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (w_req),
      .advance_i   (w_cap),
      .gnt_idx_o   (w_gnt),
      .any_valid_o (w_any)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= ST_EMPTY;
         r_log   <= '0;
         r_src   <= '0;
      end else if (w_cap) begin
         r_state                 <= ST_HELD;
         r_log.valid             <= 1'b1;
         r_log.overflow          <= racl_merge_overflow(bus.err_log_i[w_gnt].overflow, w_multi);
         r_log.racl_role         <= bus.err_log_i[w_gnt].racl_role;
         r_log.ctn_uid           <= bus.err_log_i[w_gnt].ctn_uid;
         r_log.read_access       <= bus.err_log_i[w_gnt].read_access;
         r_log.request_address   <= bus.err_log_i[w_gnt].request_address;
         r_src                   <= w_gnt;
      end else begin
         case (r_state)
            ST_HELD: begin
               if (bus.clear_i) begin
                  r_state <= ST_EMPTY;
                  r_log   <= '0;
                  r_src   <= '0;
               end else if (w_any) begin
                  // Record fields stay frozen; only the loss is remembered.
                  r_log.overflow <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_EMPTY;
            end
         endcase
      end
   end

   assign bus.err_log_o = r_log;
   assign bus.err_src_o = r_src;
   assign bus.intr_o    = r_log.valid;

`ifdef RACL_ERR_CNT_EN
   logic [NumSrc-1:0][CntW-1:0] r_cnt;

   // Counts every denial, captured or not; only reset clears them.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else begin
         for (int k = 0; k < int'(NumSrc); k++) begin
            if (w_req[k] && (r_cnt[k] != {CntW{1'b1}})) begin
               r_cnt[k] <= r_cnt[k] + CntW'(1);
            end
         end
      end
   end

   assign bus.err_cnt_o = r_cnt;
`endif

endmodule

// File: tb/tb_racl_error_log_collector.sv
// tb/tb_racl_error_log_collector.sv - self-checking bench for racl_error_log_collector
module tb_racl_error_log_collector;
   import top_racl_pkg::*;

   localparam int unsigned NUM = 4;
   localparam int unsigned CW  = 2;
   localparam int unsigned CNT_MAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   racl_error_log_collector_if #(.NumSrc(NUM), .CntW(CW)) bus ();

   racl_error_log_collector #(.NumSrc(NUM), .CntW(CW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: one slot, a rotating start position and plain counts.
   bit              m_valid;
   bit              m_ovf;
   racl_error_log_t m_rec;
   int              m_src;
   int              m_ptr;
   int              m_cnt [NUM];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic model_update();
      int q[$];
      int w;
      if (!rst_n) begin
         m_valid = 0; m_ovf = 0; m_rec = '0; m_src = 0; m_ptr = 0;
         foreach (m_cnt[k]) m_cnt[k] = 0;
         return;
      end
      for (int k = 0; k < NUM; k++) begin
         if (bus.err_log_i[k].valid) begin
            q.push_back(k);
            if (m_cnt[k] < CNT_MAX) m_cnt[k]++;
         end
      end
      if (m_valid && !bus.clear_i) begin
         if (q.size() > 0) m_ovf = 1;
      end else if (q.size() > 0) begin
         w = -1;
         for (int off = 0; off < NUM && w < 0; off++) begin
            if (bus.err_log_i[(m_ptr + off) % NUM].valid) w = (m_ptr + off) % NUM;
         end
         m_rec   = bus.err_log_i[w];
         m_valid = 1;
         m_src   = w;
         m_ovf   = (q.size() > 1) || bus.err_log_i[w].overflow;
         m_ptr   = (w + 1) % NUM;
      end else begin
         m_valid = 0;
         m_ovf   = 0;
      end
   endtask

   task automatic compare_all();
      check("valid", bus.err_log_o.valid, m_valid);
      check("intr", bus.intr_o, m_valid);
      check("ovf", bus.err_log_o.overflow, m_ovf);
      if (m_valid) begin
         check("src", bus.err_src_o, m_src);
         check("addr", bus.err_log_o.request_address, m_rec.request_address);
         check("role", bus.err_log_o.racl_role, m_rec.racl_role);
         check("uid", bus.err_log_o.ctn_uid, m_rec.ctn_uid);
         check("rd", bus.err_log_o.read_access, m_rec.read_access);
      end
`ifdef RACL_ERR_CNT_EN
      for (int k = 0; k < NUM; k++) check($sformatf("cnt%0d", k), bus.err_cnt_o[k], m_cnt[k]);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_update();
      compare_all();
   endtask

   task automatic idle();
      bus.err_log_i = '0;
      bus.clear_i   = 1'b0;
   endtask

   task automatic set_src(input int k, input logic [31:0] addr, input logic [3:0] role,
                          input logic rd, input logic ovf);
      bus.err_log_i[k].valid           = 1'b1;
      bus.err_log_i[k].overflow        = ovf;
      bus.err_log_i[k].racl_role       = role;
      bus.err_log_i[k].ctn_uid         = 8'h5A;
      bus.err_log_i[k].read_access     = rd;
      bus.err_log_i[k].request_address = addr;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      idle();
      do_reset();
      check("rst_log", bus.err_log_o, 64'd0);
      check("rst_src", bus.err_src_o, 0);
      check("rst_intr", bus.intr_o, 0);

      // Single read record from source 2.
      set_src(2, 32'h4000_1000, 4'd3, 1'b1, 1'b0);
      step();
      idle();
      check("t1_intr", bus.intr_o, 1);
      check("t1_src", bus.err_src_o, 2);
      check("t1_addr", bus.err_log_o.request_address, 32'h4000_1000);
      check("t1_role", bus.err_log_o.racl_role, 3);
      check("t1_rd", bus.err_log_o.read_access, 1);
      check("t1_ovf", bus.err_log_o.overflow, 0);

      // Simultaneous sources 0 and 3, pointer at 0.
      do_reset();
      set_src(0, 32'h100, 4'd1, 1'b0, 1'b0);
      set_src(3, 32'h300, 4'd2, 1'b0, 1'b0);
      step();
      idle();
      check("t2_src0", bus.err_src_o, 0);
      check("t2_ovf", bus.err_log_o.overflow, 1);
      bus.clear_i = 1'b1;
      step();
      idle();
      check("t2_clr_intr", bus.intr_o, 0);
      set_src(0, 32'h100, 4'd1, 1'b0, 1'b0);
      set_src(3, 32'h300, 4'd2, 1'b0, 1'b0);
      step();
      idle();
      check("t2_src3", bus.err_src_o, 3);
      check("t2_addr3", bus.err_log_o.request_address, 32'h300);

      // Record arriving while HELD only sets overflow.
      bus.clear_i = 1'b1;
      step();
      idle();
      set_src(2, 32'h2222, 4'd7, 1'b1, 1'b0);
      step();
      idle();
      set_src(1, 32'h1111, 4'd9, 1'b0, 1'b0);
      step();
      idle();
      check("t3_src", bus.err_src_o, 2);
      check("t3_addr", bus.err_log_o.request_address, 32'h2222);
      check("t3_ovf", bus.err_log_o.overflow, 1);
      bus.clear_i = 1'b1;
      step();
      idle();
      check("t3_clr_intr", bus.intr_o, 0);
      check("t3_clr_ovf", bus.err_log_o.overflow, 0);

      // Clear plus new record in the same cycle.
      set_src(2, 32'h2222, 4'd7, 1'b1, 1'b0);
      step();
      idle();
      bus.clear_i = 1'b1;
      set_src(0, 32'h0ABC, 4'd4, 1'b0, 1'b0);
      step();
      idle();
      check("t4_intr", bus.intr_o, 1);
      check("t4_src", bus.err_src_o, 0);
      check("t4_addr", bus.err_log_o.request_address, 32'h0ABC);
      check("t4_ovf", bus.err_log_o.overflow, 0);

      // Reset while HELD with source 1 valid.
      rst_n = 1'b0;
      set_src(1, 32'h7777, 4'd5, 1'b1, 1'b0);
      step();
      idle();
      rst_n = 1'b1;
      check("t5_log", bus.err_log_o, 64'd0);
      check("t5_src", bus.err_src_o, 0);
      check("t5_intr", bus.intr_o, 0);
      step();
      check("t5_intr_after", bus.intr_o, 0);

`ifdef RACL_ERR_CNT_EN
      // Saturating counter on source 1.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_src(1, 32'h10 + 32'(i), 4'd1, 1'b0, 1'b0);
         step();
         idle();
         step();
      end
      check("t6_cnt_sat", bus.err_cnt_o[1], 3);
      bus.clear_i = 1'b1;
      step();
      idle();
      check("t6_cnt_after_clr", bus.err_cnt_o[1], 3);
`endif

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         rst_n       = ($urandom_range(0, 59) != 0);
         bus.clear_i = ($urandom_range(0, 3) == 0);
         for (int k = 0; k < NUM; k++) begin
            bus.err_log_i[k].valid           = ($urandom_range(0, 3) == 0);
            bus.err_log_i[k].overflow        = ($urandom_range(0, 7) == 0);
            bus.err_log_i[k].racl_role       = 4'($urandom);
            bus.err_log_i[k].ctn_uid         = 8'($urandom);
            bus.err_log_i[k].read_access     = 1'($urandom);
            bus.err_log_i[k].request_address = $urandom;
         end
         step();
      end
      idle();
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/racl_error_log_collector.md
# racl_error_log_collector

Collects RACL denial records from several RACL-checking TL-UL endpoints into one captured error log with sticky overflow, interrupt and software clear. Sits directly downstream of the per-IP RACL checks, which produce `top_racl_pkg::racl_error_log_t` records. Feeds the top-level RACL error CSRs and the interrupt line.

## Interface
- `NumSrc`, default 4: number of RACL-checking sources (1..16).
- `CntW`, default 8: width of the per-source denial counters (only used with the `RACL_ERR_CNT_EN` macro).
- `clk_i  in  1`: clock, the only clock.
- `rst_ni  in  1`: reset, synchronous and active-low.
- `err_log_i  in  NumSrc x racl_error_log_t`: per-source record; `.valid` is a single-cycle pulse.
- `clear_i  in  1`: single-cycle pulse from the CSR write; releases the captured log.
- `err_log_o  out  racl_error_log_t`: captured record; `.overflow` is the sticky merged flag.
- `err_src_o  out  SrcW`: index of the source whose record was captured.
- `intr_o  out  1`: level interrupt, equal to `err_log_o.valid`.
- `err_cnt_o  out  NumSrc x CntW`: per-source denial counts (only with `RACL_ERR_CNT_EN`).

## Operation
- States:
  - EMPTY: `err_log_o.valid`=0.
  - HELD: `err_log_o.valid`=1.
- EMPTY, with at least one `err_log_i[k].valid`:
  - A round-robin arbiter picks the winner.
  - Capture `request_address`, `racl_role`, `ctn_uid` and `read_access` from the winner.
  - Set `err_src_o`=k.
  - Go to HELD.
- Overflow is set at capture when either:
  - two or more sources are valid in that cycle, or
  - the winner's own `.overflow` bit is 1.
- HELD, any `err_log_i[*].valid` and no `clear_i`:
  - Record fields do not change.
  - `overflow` is set to 1 and is sticky.
- HELD with `clear_i`:
  - Return to EMPTY; `overflow` is cleared.
  - If a valid input arrives in the same cycle, it is captured as a fresh record (go straight to HELD, not EMPTY).
  - That fresh record's `overflow` follows the capture rule above.
- `clear_i` in EMPTY has no effect.
- Arbiter:
  - The pointer starts at 0.
  - After each capture the pointer moves to winner+1, mod `NumSrc`.
  - The search starts at the pointer and wraps around.
  - The pointer does not move in HELD.
- Width rules:
  - `SrcW = (NumSrc<=1) ? 1 : $clog2(NumSrc)`.
  - Counters saturate at 2^CntW−1 and do not wrap.

## Timing
- All outputs are registered; capture latency is 1 cycle (input valid in cycle n → `err_log_o` and `intr_o` in cycle n+1).
- Clear latency is 1 cycle: `intr_o` is low in cycle n+1 unless a new capture happens in the same cycle.
- Reset values: all of `err_log_o` = 0, `err_src_o` = 0, `intr_o` = 0, all counters = 0, arbiter pointer = 0.
- A reset asserted in the middle of HELD drops the record with no capture, even if inputs are valid in that cycle.
- There is no backpressure: inputs are never stalled. A record that is not captured contributes only to overflow and the counters.

## Configuration
- The macro is `RACL_ERR_CNT_EN`.
- With `RACL_ERR_CNT_EN` defined:
  - Each source has a saturating counter.
  - The counter increments on every `err_log_i[k].valid`, whether or not that record is captured.
  - The counters are not cleared by `clear_i`, only by reset.
  - The `err_cnt_o` port exists.
- Without it:
  - There are no counters.
  - The `err_cnt_o` port is absent.

## Structure
- Add to `top_racl_pkg`:
  - `RACL_ERR_SRC_MAX` = 16.
  - A typedef for the source index.
  - A function that merges overflow from a record's `.overflow` bit and the multi-valid condition.
- Reuse `racl_error_log_t` from the package unchanged.
- Sub-module: `racl_err_rr_arb`. It is a combinational round-robin pick with a registered pointer, taking `NumSrc` requests and returning grant index plus any-valid.

## Test plan
- Source 2 sends a read record with address 0x4000_1000, role 3 and no other traffic. In the next cycle: `intr_o`=1, `err_src_o`=2, address 0x4000_1000, role 3, `read_access`=1, `overflow`=0.
- Sources 0 and 3 are valid in the same cycle from EMPTY with the pointer at 0. Capture source 0 with `overflow`=1. After `clear_i`, sources 0 and 3 are valid again: capture source 3 (pointer is 1).
- A source-1 record arrives while HELD. The held record is unchanged and `overflow` becomes 1. After `clear_i`, in the next cycle `intr_o`=0 and `overflow`=0.
- `clear_i` and a source-0 valid arrive in the same cycle while HELD. The next cycle shows the new source-0 record, `intr_o`=1 and `overflow`=0.
- `rst_ni`=0 for one cycle while HELD, with source 1 valid in that cycle. All outputs are 0 afterwards and nothing is captured.
- With `RACL_ERR_CNT_EN` and `CntW`=2, send 5 pulses on source 1. `err_cnt_o[1]`=3 (saturated) and it stays 3 after `clear_i`.
